// File: rtl/seg_scan_capture.sv
// seg_scan_capture
// Receive-side monitor for the multiplexed 4-digit seven-segment display bus.
// It synchronizes the active-low anode strobes and segment lines, waits for each
// strobe to settle, decodes the segment pattern back to a digit, and assembles
// complete 4-digit frames onto led_0..led_3. A frame holding any bad strobe or
// pattern is discarded with a frame_err pulse. The stale flag is raised when no
// capture has arrived for TIMEOUT_CYCLES.
// Optional feature: define SEG_HEX_EXT_EN to accept the A..F patterns as 10..15.

module seg_scan_capture #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_data,
    input  logic [3:0] AN,
    output logic [3:0] led_0,
    output logic [3:0] led_1,
    output logic [3:0] led_2,
    output logic [3:0] led_3,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       stale
);

    localparam int unsigned CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    // Capture fires on the cycle the settle counter steps onto STABLE_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]    AN_BLANK = 4'b1111;

    typedef enum logic {
        SETTLE,
        HELD
    } state_e;

    // Synchronizers and previous-sample register
    logic [3:0]  an_s1_q,  an_s1_d;
    logic [3:0]  an_s2_q,  an_s2_d;
    logic [6:0]  seg_s1_q, seg_s1_d;
    logic [6:0]  seg_s2_q, seg_s2_d;
    logic [10:0] prev_q,   prev_d;
    logic [10:0] sample;
    logic        same;

    // Strobe FSM
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          capture;

    // Frame assembly and outputs
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0][3:0] led_q,    led_d;
    logic [3:0]      mask_q,   mask_d;
    logic            err_q,    err_d;
    logic [TW-1:0]   tmo_q,    tmo_d;
    logic            fv_q,     fv_d;
    logic            fe_q,     fe_d;
    logic            stale_q,  stale_d;

    logic [4:0] dec;
    logic [1:0] an_idx;
    logic       an_ok;
    logic       refresh;

    // Active-low pattern decode; bit 4 flags a recognised digit.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] r;
        r = '0;
        case (pat)
            7'b0000001: r = {1'b1, 4'd0};
            7'b1001111: r = {1'b1, 4'd1};
            7'b0010010: r = {1'b1, 4'd2};
            7'b0000110: r = {1'b1, 4'd3};
            7'b1001100: r = {1'b1, 4'd4};
            7'b0100100: r = {1'b1, 4'd5};
            7'b0100000: r = {1'b1, 4'd6};
            7'b0001111: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0000100: r = {1'b1, 4'd9};
`ifdef SEG_HEX_EXT_EN
            7'b0001000: r = {1'b1, 4'd10};
            7'b1100000: r = {1'b1, 4'd11};
            7'b0110001: r = {1'b1, 4'd12};
            7'b1000010: r = {1'b1, 4'd13};
            7'b0110000: r = {1'b1, 4'd14};
            7'b0111000: r = {1'b1, 4'd15};
`endif
            default:    r = '0;
        endcase
        return r;
    endfunction

    // Two-flop synchronizer chain plus the one-cycle-old sample for change detection
    always_comb begin
        an_s1_d  = AN;
        an_s2_d  = an_s1_q;
        seg_s1_d = seg_data;
        seg_s2_d = seg_s1_q;
        sample   = {an_s2_q, seg_s2_q};
        prev_d   = sample;
        same     = (sample == prev_q);
    end

    // Synchronizer registers; reset to the blank (all-ones) bus state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_s1_q  <= '1;
            an_s2_q  <= '1;
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            prev_q   <= '1;
        end else begin
            an_s1_q  <= an_s1_d;
            an_s2_q  <= an_s2_d;
            seg_s1_q <= seg_s1_d;
            seg_s2_q <= seg_s2_d;
            prev_q   <= prev_d;
        end
    end

    // Strobe FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobe FSM next state: count stable samples, then hold until the bus moves
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SETTLE: begin
                if (!same) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (!same) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobe FSM output: one capture strobe per settled bus value
    always_comb begin
        capture = (state_q == SETTLE) && same && (cnt_q == CNT_LAST);
    end

    // Capture action, frame assembly and timeout; a capture always beats expiry
    always_comb begin
        shadow_d = shadow_q;
        led_d    = led_q;
        mask_d   = mask_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        stale_d  = stale_q;
        refresh  = 1'b0;
        dec      = seg_decode(seg_s2_q);
        an_ok    = 1'b1;
        an_idx   = 2'd0;

        case (an_s2_q)
            4'b0111: an_idx = 2'd0;
            4'b1011: an_idx = 2'd1;
            4'b1101: an_idx = 2'd2;
            4'b1110: an_idx = 2'd3;
            default: an_ok  = 1'b0;
        endcase

        if (capture && (an_s2_q != AN_BLANK)) begin
            refresh = 1'b1;
            if (an_ok) begin
                mask_d[an_idx] = 1'b1;
                if (dec[4]) begin
                    shadow_d[an_idx] = dec[3:0];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (refresh) begin
            tmo_d = '0;
            if (mask_d == 4'b1111) begin
                if (!err_d) begin
                    led_d   = shadow_d;
                    fv_d    = 1'b1;
                    stale_d = 1'b0;
                end else begin
                    fe_d = 1'b1;
                end
                mask_d = '0;
                err_d  = 1'b0;
            end
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_MAX) begin
                stale_d = 1'b1;
                mask_d  = '0;
                err_d   = 1'b0;
            end
        end
    end

    // Frame assembly and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            led_q    <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            stale_q  <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            led_q    <= led_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            stale_q  <= stale_d;
        end
    end

    assign led_0       = led_q[0];
    assign led_1       = led_q[1];
    assign led_2       = led_q[2];
    assign led_3       = led_q[3];
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign stale       = stale_q;

endmodule
